// File: rtl/trn_dac_axil_regbank.sv
// AXI4-Lite register bank for the DAC3482 interface.
// Index 0 is a write-1-to-pulse command register. Next come the RW control
// registers. The top C_NUM_RO indices are read-only status words.
module trn_dac_axil_regbank #(
    parameter int C_NUM_REGS         = 16,
    parameter int C_NUM_RO           = 4,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_awaddr,
    input  logic [2:0]                    s00_axi_awprot,
    input  logic                          s00_axi_awvalid,
    output logic                          s00_axi_awready,
    input  logic [31:0]                   s00_axi_wdata,
    input  logic [3:0]                    s00_axi_wstrb,
    input  logic                          s00_axi_wvalid,
    output logic                          s00_axi_wready,
    output logic [1:0]                    s00_axi_bresp,
    output logic                          s00_axi_bvalid,
    input  logic                          s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
    input  logic [2:0]                    s00_axi_arprot,
    input  logic                          s00_axi_arvalid,
    output logic                          s00_axi_arready,
    output logic [31:0]                   s00_axi_rdata,
    output logic [1:0]                    s00_axi_rresp,
    output logic                          s00_axi_rvalid,
    input  logic                          s00_axi_rready,
    output logic [C_NUM_REGS*32-1:0]      ctrl_out,
    input  logic [C_NUM_RO*32-1:0]        status_in,
    output logic [C_NUM_REGS-1:0]         wr_strobe,
    output logic [31:0]                   cmd_pulse
);

    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
    localparam int NRW = C_NUM_REGS - C_NUM_RO;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic          aw_held;
    logic          w_held;
    logic [IW-1:0] aw_idx_q;
    logic [31:0]   w_data_q;
    logic [3:0]    w_strb_q;
    logic [31:0]   regs_q [1:NRW-1];

    logic          aw_fire;
    logic          w_fire;
    logic          ar_fire;
    logic          commit;
    logic [IW-1:0] wr_idx;
    logic [31:0]   wr_data;
    logic [3:0]    wr_strb;
    int            wr_idx_i;
    int            rd_idx_i;
    logic          unused_bits;

    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign s00_axi_awready = ~aw_held & ~s00_axi_bvalid;
    assign s00_axi_wready  = ~w_held & ~s00_axi_bvalid;
    assign s00_axi_arready = ~s00_axi_rvalid;

    assign aw_fire = s00_axi_awvalid & s00_axi_awready;
    assign w_fire  = s00_axi_wvalid & s00_axi_wready;
    assign ar_fire = s00_axi_arvalid & s00_axi_arready;
    assign commit  = (aw_fire | aw_held) & (w_fire | w_held);

    // Commit uses this cycle's AW/W values when present, otherwise the held copies
    always_comb begin
        wr_idx  = aw_fire ? s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2] : aw_idx_q;
        wr_data = w_fire ? s00_axi_wdata : w_data_q;
        wr_strb = w_fire ? s00_axi_wstrb : w_strb_q;
    end

    assign wr_idx_i = int'(wr_idx);
    assign rd_idx_i = int'(s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2]);

    // Write channel: hold whichever of AW/W arrives first, commit when both are in
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            aw_idx_q       <= '0;
            w_data_q       <= '0;
            w_strb_q       <= '0;
            s00_axi_bvalid <= 1'b0;
            s00_axi_bresp  <= RESP_OKAY;
            wr_strobe      <= '0;
            cmd_pulse      <= '0;
            for (int i = 1; i < NRW; i++) regs_q[i] <= '0;
        end else begin
            wr_strobe <= '0;
            cmd_pulse <= '0;
            if (s00_axi_bvalid && s00_axi_bready) s00_axi_bvalid <= 1'b0;
            if (commit) begin
                aw_held        <= 1'b0;
                w_held         <= 1'b0;
                s00_axi_bvalid <= 1'b1;
                s00_axi_bresp  <= (wr_idx_i < NRW) ? RESP_OKAY : RESP_SLVERR;
                if (wr_idx_i == 0) begin
                    for (int b = 0; b < 32; b++) cmd_pulse[b] <= wr_data[b] & wr_strb[b/8];
                end
                for (int i = 1; i < NRW; i++) begin
                    if (wr_idx_i == i) begin
                        wr_strobe[i] <= 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (wr_strb[b]) regs_q[i][8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
                end
            end else begin
                if (aw_fire) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
                end
                if (w_fire) begin
                    w_held   <= 1'b1;
                    w_data_q <= s00_axi_wdata;
                    w_strb_q <= s00_axi_wstrb;
                end
            end
        end
    end

    // Read channel: register data/response on AR, hold until rready
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            s00_axi_rvalid <= 1'b0;
            s00_axi_rdata  <= '0;
            s00_axi_rresp  <= RESP_OKAY;
        end else begin
            if (s00_axi_rvalid && s00_axi_rready) s00_axi_rvalid <= 1'b0;
            if (ar_fire) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= '0;
                s00_axi_rresp  <= (rd_idx_i >= C_NUM_REGS) ? RESP_SLVERR : RESP_OKAY;
                for (int i = 1; i < NRW; i++) begin
                    if (rd_idx_i == i) s00_axi_rdata <= regs_q[i];
                end
                for (int k = 0; k < C_NUM_RO; k++) begin
                    if (rd_idx_i == NRW + k) s00_axi_rdata <= status_in[32*k +: 32];
                end
            end
        end
    end

    // Flattened control view; command and status slots read as zero
    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_ctrl
        if (g >= 1 && g < NRW) begin : g_rw
            assign ctrl_out[32*g +: 32] = regs_q[g];
        end else begin : g_zero
            assign ctrl_out[32*g +: 32] = '0;
        end
    end

endmodule

// File: tb/tb_trn_dac_axil_regbank.sv
module tb_trn_dac_axil_regbank;

    localparam int NREGS = 16;
    localparam int NRO   = 4;
    localparam int AW    = 6;

    logic              clk = 1'b0;
    logic              areset = 1'b1;
    logic [AW-1:0]     awaddr = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [31:0]       wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b1;
    logic [AW-1:0]     araddr = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b1;
    logic [NREGS*32-1:0] ctrl_out;
    logic [NRO*32-1:0] status_in;
    logic [NREGS-1:0]  wr_strobe;
    logic [31:0]       cmd_pulse;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    rexp_t       rq[$];
    logic [1:0]  bq[$];
    int          checks = 0;
    int          errors = 0;

    trn_dac_axil_regbank #(
        .C_NUM_REGS(NREGS), .C_NUM_RO(NRO), .C_S_AXI_ADDR_WIDTH(AW)
    ) dut (
        .s00_axi_aclk(clk), .s00_axi_areset(areset),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(3'b000),
        .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(3'b000),
        .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
        .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .ctrl_out(ctrl_out), .status_in(status_in),
        .wr_strobe(wr_strobe), .cmd_pulse(cmd_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs AW/W/AR handshakes for whatever is currently valid, bounded
    task automatic handshake();
        logic a, w, r;
        for (int c = 0; c < 20; c++) begin
            if (!awvalid && !wvalid && !arvalid) break;
            @(negedge clk);
            a = awvalid && awready;
            w = wvalid && wready;
            r = arvalid && arready;
            @(posedge clk); #1;
            if (a) awvalid = 1'b0;
            if (w) wvalid = 1'b0;
            if (r) arvalid = 1'b0;
        end
        chk("handshake_timeout", {61'd0, awvalid, wvalid, arvalid}, 64'd0);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp,
                            input logic [15:0] exp_strobe, input logic [31:0] exp_cmd,
                            input int w_lead, input int hold_b);
        logic [1:0] eb;
        logic       early_b;
        bq.push_back(resp);
        bready = (hold_b == 0);
        awaddr = addr; wdata = data; wstrb = strb;
        if (w_lead > 0) begin
            wvalid = 1'b1;
            handshake();
            early_b = 1'b0;
            for (int k = 0; k < w_lead; k++) begin
                @(negedge clk);
                early_b = early_b | bvalid | (wr_strobe != 0);
                chk("wready_while_w_held", {63'd0, wready}, 64'd0);
                @(posedge clk); #1;
            end
            chk("no_commit_before_aw", {63'd0, early_b}, 64'd0);
            awvalid = 1'b1;
        end else begin
            awvalid = 1'b1;
            wvalid  = 1'b1;
        end
        handshake();
        chk("b_queue_nonempty", {63'd0, bq.size() != 0}, 64'd1);
        eb = bq.pop_front();
        @(negedge clk);
        chk("b_latency", {63'd0, bvalid}, 64'd1);
        chk("wr_strobe", {48'd0, wr_strobe}, {48'd0, exp_strobe});
        chk("cmd_pulse", {32'd0, cmd_pulse}, {32'd0, exp_cmd});
        for (int k = 0; k < hold_b; k++) begin
            chk("b_backpressure", {59'd0, awready, wready, bvalid, bresp},
                {59'd0, 1'b0, 1'b0, 1'b1, eb});
            @(posedge clk); #1;
            @(negedge clk);
        end
        bready = 1'b1;
        chk("bresp", {62'd0, bresp}, {62'd0, eb});
        @(posedge clk); #1;
        @(negedge clk);
        chk("pulses_one_cycle", {15'd0, bvalid, wr_strobe, cmd_pulse}, 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [1:0] resp);
        rexp_t e;
        rq.push_back('{data: data, resp: resp});
        araddr = addr;
        arvalid = 1'b1;
        handshake();
        chk("r_queue_nonempty", {63'd0, rq.size() != 0}, 64'd1);
        e = rq.pop_front();
        @(negedge clk);
        chk("r_latency", {63'd0, rvalid}, 64'd1);
        chk("rdata", {32'd0, rdata}, {32'd0, e.data});
        chk("rresp", {62'd0, rresp}, {62'd0, e.resp});
        @(posedge clk); #1;
    endtask

    initial begin
        logic no_b;
        status_in = {32'hC0FFEE03, 32'hDEADBEEF, 32'h0000A5A1, 32'h5A5A0000};
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_ready", {61'd0, awready, wready, arready}, 64'h7);
        chk("reset_valid_resp", {58'd0, bvalid, rvalid, bresp, rresp}, 64'd0);
        chk("reset_rdata", {32'd0, rdata}, 64'd0);
        chk("reset_ctrl_out", {63'd0, ctrl_out != 0}, 64'd0);
        chk("reset_pulses", {16'd0, wr_strobe, cmd_pulse}, 64'd0);
        @(posedge clk); #1;
        areset = 1'b0;

        // basic RW
        for (int i = 1; i <= 11; i++)
            do_write(AW'(4 * i), 32'(i), 4'hF, 2'b00, 16'(1 << i), 32'd0, 0, 0);
        for (int i = 1; i <= 11; i++)
            chk("ctrl_out_slot", {32'd0, ctrl_out[32*i +: 32]}, {32'd0, 32'(i)});
        for (int i = 1; i <= 11; i++)
            do_read(AW'(4 * i), 32'(i), 2'b00);

        // byte strobes
        do_write(6'h08, 32'hAABBCCDD, 4'hF, 2'b00, 16'h0004, 32'd0, 0, 0);
        do_write(6'h08, 32'h11223344, 4'b0101, 2'b00, 16'h0004, 32'd0, 0, 0);
        do_read(6'h08, 32'hAA22CC44, 2'b00);

        // W three cycles ahead of AW, then blocked B channel
        do_write(6'h0C, 32'h12345678, 4'hF, 2'b00, 16'h0008, 32'd0, 3, 0);
        do_read(6'h0C, 32'h12345678, 2'b00);
        do_write(6'h10, 32'h0BADF00D, 4'hF, 2'b00, 16'h0010, 32'd0, 0, 5);
        do_read(6'h10, 32'h0BADF00D, 2'b00);

        // status region and errors
        do_write(6'h30, 32'hFFFFFFFF, 4'hF, 2'b10, 16'h0000, 32'd0, 0, 0);
        do_read(6'h30, 32'h5A5A0000, 2'b00);
        do_read(6'h38, 32'hDEADBEEF, 2'b00);
        do_read(6'h3C, 32'hC0FFEE03, 2'b00);

        // command register
        do_write(6'h00, 32'h00000005, 4'hF, 2'b00, 16'h0000, 32'h00000005, 0, 0);
        do_write(6'h00, 32'hFFFFFFFF, 4'b0010, 2'b00, 16'h0000, 32'h0000FF00, 0, 0);
        do_read(6'h00, 32'h00000000, 2'b00);

        // reset after AW but before W
        awaddr = 6'h14; awvalid = 1'b1;
        handshake();
        areset = 1'b1;
        wdata = 32'h99999999; wstrb = 4'hF;
        @(posedge clk); #1;
        areset = 1'b0;
        no_b = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            no_b = no_b | bvalid | (wr_strobe != 0);
            @(posedge clk); #1;
        end
        chk("reset_mid_no_commit", {63'd0, no_b}, 64'd0);
        chk("reset_mid_ctrl_zero", {63'd0, ctrl_out != 0}, 64'd0);
        do_write(6'h14, 32'hFEEDFACE, 4'hF, 2'b00, 16'h0020, 32'd0, 0, 0);
        chk("post_reset_ctrl", {32'd0, ctrl_out[32*5 +: 32]}, {32'd0, 32'hFEEDFACE});
        do_read(6'h14, 32'hFEEDFACE, 2'b00);
        do_read(6'h04, 32'h00000000, 2'b00);

        chk("queues_drained", {32'd0, 16'(rq.size()), 16'(bq.size())}, 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trn_dac_axil_regbank.md
# trn_dac_axil_regbank

Parametrised AXI4-Lite slave register bank for the DAC3482 interface IP, generalising the fixed four-register S00_AXI slave.
- Supports a configurable register count and byte-lane write strobes.
- Provides a read-only status region sampled from the DAC datapath.
- Provides a write-1-to-pulse command register.
- Issues error responses for illegal accesses.
- Sits between the AXI interconnect and the DAC control/datapath logic.

## Interface
- C_NUM_REGS, 16, total 32-bit registers; power of 2, range 4..256.
- C_NUM_RO, 4, read-only status registers occupying the top C_NUM_RO indices; must be less than C_NUM_REGS-1.
- C_S_AXI_ADDR_WIDTH, 6, byte-address width; must be at least log2(C_NUM_REGS)+2.
- Clocking and reset: one clock; reset is synchronous and active-high.
- s00_axi_aclk  in  1  clock.
- s00_axi_areset  in  1  synchronous active-high reset.
- s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid / s00_axi_awready  in / out  1 each  AW handshake.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte strobes.
- s00_axi_wvalid / s00_axi_wready  in / out  1 each  W handshake.
- s00_axi_bresp  out  2  write response.
- s00_axi_bvalid / s00_axi_bready  out / in  1 each  B handshake.
- s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid / s00_axi_arready  in / out  1 each  AR handshake.
- s00_axi_rdata  out  32  read data.
- s00_axi_rresp  out  2  read response.
- s00_axi_rvalid / s00_axi_rready  out / in  1 each  R handshake.
- ctrl_out  out  C_NUM_REGS*32  flattened RW register contents; slot i is bits [32i+31:32i]; slot 0 and RO slots are always 0.
- status_in  in  C_NUM_RO*32  status words; word k maps to index C_NUM_REGS-C_NUM_RO+k.
- wr_strobe  out  C_NUM_REGS  one-cycle pulse on bit i when RW register i commits.
- cmd_pulse  out  32  one-cycle pulses from the command register.

## Operation
Address decode:
- Register index = addr[C_S_AXI_ADDR_WIDTH-1:2]; addr[1:0] is ignored.
- Indices at or above C_NUM_REGS are out of range. They can only occur when C_S_AXI_ADDR_WIDTH > log2(C_NUM_REGS)+2.

Register map:
- Index 0, command: a write sets cmd_pulse[b] for every bit b where wdata[b]=1 and its byte strobe is set. Reads return 0. Response OKAY.
- Indices 1..C_NUM_REGS-C_NUM_RO-1, RW: each byte lane is updated only where its wstrb bit is 1. Response OKAY.
- RO indices: writes are dropped and return SLVERR (2'b10); reads return the corresponding status_in word.
- Out of range: writes are dropped and return SLVERR; reads return data 0 with SLVERR.

Write path:
- AW and W are accepted independently and in either order.
- awready = ~aw_held & ~bvalid; wready = ~w_held & ~bvalid.
- Commit happens on the edge at which the second of AW/W completes its handshake. Same-cycle values are used directly; nothing extra is latched.
- At commit, aw_held and w_held clear and bvalid sets.
- bvalid holds, with bresp stable, until bready is sampled high.

Read path:
- arready = ~rvalid.
- On an AR handshake, rdata/rresp are registered (status_in sampled at that edge) and rvalid sets.
- rvalid holds until rready is sampled high.

Write/read ordering:
- Read and write paths are fully independent.
- If an AR handshake occurs on the same edge as a commit to the same register, the read returns the pre-write value.

## Timing
- Reset values: awready, wready, arready = 1; bvalid, rvalid = 0; bresp, rresp, rdata = 0; ctrl_out, wr_strobe, cmd_pulse = 0.
- Reset mid-transaction discards held AW/W and pending B/R; no commit occurs in the reset cycle.
- Write latency: AW and W both accepted in cycle 0 gives bvalid, the updated ctrl_out and wr_strobe/cmd_pulse in cycle 1. wr_strobe and cmd_pulse are high for exactly cycle 1.
- AW in cycle 0 and W in cycle 3 gives commit at the cycle-3 edge and bvalid in cycle 4. wready stays high during cycles 1..3.
- Write throughput with bready held high: one write per 2 cycles.
- Read latency: AR in cycle 0 gives rvalid in cycle 1. Throughput with rready held high is one read per 2 cycles.
- Backpressure: while bready=0 no new AW/W is accepted; while rready=0 no new AR is accepted.

## Test plan
- Parameters for all scenarios: C_NUM_REGS=16, C_NUM_RO=4, C_S_AXI_ADDR_WIDTH=6.
- Basic RW: write 0x1..0xB to addresses 0x04..0x2C, then read them back → each read returns its written value with OKAY; wr_strobe[i] pulses once per write.
- Byte strobes: reg 0x08 holds 0xAABBCCDD; write 0x11223344 with wstrb=4'b0101 → reads 0xAA22CC44.
- Skewed and blocked handshakes:
  - W three cycles before AW → a single commit, with bvalid one cycle after the AW handshake.
  - bready low for 5 cycles → awready and wready stay 0 during that time and bresp holds stable.
- Errors:
  - Write to 0x30 → SLVERR and status is unaffected.
  - status_in word 2 = 0xDEADBEEF; read 0x38 → 0xDEADBEEF with OKAY.
- Command register: write 0x00000005 to 0x00 → cmd_pulse=0x5 for exactly one cycle; a read of 0x00 returns 0.
- Reset mid-transaction: assert reset after the AW handshake but before W → no commit, bvalid stays 0, ctrl_out=0; afterwards a fresh write completes normally.
